// File: rtl/cofre_timelock_if.sv
// cofre_timelock_if: switch inputs and LED/alarm outputs of the vault time-lock.
// master drives code/enter/door_open/mgr_key and reads the status outputs.
// slave (the controller) consumes the switches and drives hour/expediente/unlock/lockout/alarm/tries.
interface cofre_timelock_if;
    logic [3:0] code;
    logic       enter;
    logic       door_open;
    logic       mgr_key;
    logic [4:0] hour;
    logic       expediente;
    logic       unlock;
    logic       lockout;
    logic       alarm;
    logic [2:0] tries;
    modport master (
        output code, enter, door_open, mgr_key,
        input  hour, expediente, unlock, lockout, alarm, tries
    );
    modport slave (
        input  code, enter, door_open, mgr_key,
        output hour, expediente, unlock, lockout, alarm, tries
    );
endinterface

// File: rtl/cofre_timelock.sv
// cofre_timelock: vault hour clock, business-hours flag, timed unlock window, wrong-code lockout, sticky alarm.
// Ports: clk_2 clock, reset async active-high, bus (cofre_timelock_if.slave) carrying switches and outputs.
// Macro COFRE_LOCKOUT_EN builds the tries counter and LOCKOUT state; undefined ties tries/lockout to 0.
module cofre_timelock #(
    parameter int         TICKS_PER_HOUR = 30,
    parameter int         RESET_HOUR     = 8,
    parameter int         OPEN_HOUR      = 10,
    parameter int         CLOSE_HOUR     = 16,
    parameter logic [3:0] CODE           = 4'hA,
    parameter int         MAX_TRIES      = 3,
    parameter int         UNLOCK_CYCLES  = 8
) (
    input logic            clk_2,
    input logic            reset,
    cofre_timelock_if.slave bus
);
    localparam int PW = TICKS_PER_HOUR > 1 ? $clog2(TICKS_PER_HOUR) : 1;
    localparam int WW = $clog2(UNLOCK_CYCLES + 1);
    localparam logic [1:0] LOCKED   = 2'd0;
    localparam logic [1:0] UNLOCKED = 2'd1;
`ifdef COFRE_LOCKOUT_EN
    localparam logic [1:0] LOCKOUT  = 2'd2;
`endif
    logic [PW-1:0] presc;
    logic [4:0]    hour_q;
    logic [1:0]    state, state_n;
    logic [WW-1:0] win, win_n;
    logic          enter_q, mgr_q, alarm_q;
    logic          enter_edge, mgr_edge, expediente, presc_tc, alarm_set;
    assign enter_edge = bus.enter & ~enter_q;
    assign mgr_edge   = bus.mgr_key & ~mgr_q;
    assign expediente = hour_q >= 5'(OPEN_HOUR) && hour_q < 5'(CLOSE_HOUR);
    assign presc_tc   = presc == PW'(TICKS_PER_HOUR - 1);
    assign alarm_set  = bus.door_open & (state != UNLOCKED);
    assign bus.hour       = hour_q;
    assign bus.expediente = expediente;
    assign bus.unlock     = state == UNLOCKED;
    assign bus.alarm      = alarm_q;
`ifdef COFRE_LOCKOUT_EN
    logic [2:0] tries_q, tries_n;
    assign bus.tries   = tries_q;
    assign bus.lockout = state == LOCKOUT;
`else
    logic unused_cfg;
    assign unused_cfg  = |3'(MAX_TRIES);
    assign bus.tries   = '0;
    assign bus.lockout = 1'b0;
`endif
    // A simultaneous manager-key edge swallows the enter edge.
    always_comb begin
        state_n = state;
        win_n   = win;
`ifdef COFRE_LOCKOUT_EN
        tries_n = tries_q;
`endif
        if (state == UNLOCKED) begin
            win_n   = win - WW'(1);
            state_n = (!expediente || win == WW'(1)) ? LOCKED : UNLOCKED;
        end else if (state == LOCKED && enter_edge && !mgr_edge && expediente) begin
            if (bus.code == CODE) begin
                state_n = UNLOCKED;
                win_n   = WW'(UNLOCK_CYCLES);
`ifdef COFRE_LOCKOUT_EN
                tries_n = '0;
`endif
            end
`ifdef COFRE_LOCKOUT_EN
            else begin
                tries_n = tries_q + 3'd1;
                state_n = tries_n == 3'(MAX_TRIES) ? LOCKOUT : LOCKED;
            end
`endif
        end
`ifdef COFRE_LOCKOUT_EN
        else if (state == LOCKOUT && mgr_edge) begin
            state_n = LOCKED;
            tries_n = '0;
        end
`endif
    end
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            presc   <= '0;
            hour_q  <= 5'(RESET_HOUR);
            state   <= LOCKED;
            win     <= '0;
            enter_q <= 1'b0;
            mgr_q   <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            presc   <= presc_tc ? '0 : presc + PW'(1);
            if (presc_tc)
                hour_q <= hour_q == 5'd23 ? 5'd0 : hour_q + 5'd1;
            state   <= state_n;
            win     <= win_n;
            enter_q <= bus.enter;
            mgr_q   <= bus.mgr_key;
            alarm_q <= alarm_set | (alarm_q & ~mgr_edge);
        end
    end
`ifdef COFRE_LOCKOUT_EN
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset)
            tries_q <= '0;
        else
            tries_q <= tries_n;
    end
`endif
endmodule

// File: tb/tb_cofre_timelock.sv
// tb_cofre_timelock: directed scoreboard bench for cofre_timelock with TICKS_PER_HOUR=2.
module tb_cofre_timelock;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc;
  int errors = 0;
  int checks = 0;
  string names[$];
  logic [11:0] exps[$];
  string n;
  logic [11:0] e, a;
  event sample_now;
`ifdef COFRE_LOCKOUT_EN
  localparam bit LE = 1'b1;
`else
  localparam bit LE = 1'b0;
`endif
  cofre_timelock_if bus();
  cofre_timelock #(.TICKS_PER_HOUR(2)) dut (.clk_2(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk or posedge rst) begin
    if (rst)
      cyc <= 0;
    else
      cyc <= cyc + 1;
  end
  task automatic chk_h(input string nm, input int h, input bit unl, input bit lo, input bit al, input int tr);
    names.push_back(nm);
    exps.push_back({5'(h), (h >= 10 && h < 16), unl, lo, al, 3'(tr)});
  endtask
  task automatic chk(input string nm, input bit unl, input bit lo, input bit al, input int tr);
    chk_h(nm, (8 + cyc / 2) % 24, unl, lo, al, tr);
  endtask
  task automatic expect_now(input string nm, input logic [11:0] ex);
    logic [11:0] act;
    act = {bus.hour, bus.expediente, bus.unlock, bus.lockout, bus.alarm, bus.tries};
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s actual=%b required=%b (hour,exp,unl,lo,al,tries)", nm, act, ex);
    end
  endtask
  task automatic step(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #2;
    end
  endtask
  always @(negedge clk or sample_now) begin
    while (exps.size() > 0) begin
      n = names.pop_front();
      e = exps.pop_front();
      a = {bus.hour, bus.expediente, bus.unlock, bus.lockout, bus.alarm, bus.tries};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s actual=%b required=%b (hour,exp,unl,lo,al,tries)", n, a, e);
      end
    end
  end
  initial begin
    bus.code = 4'h0; bus.enter = 1'b0; bus.door_open = 1'b0; bus.mgr_key = 1'b0;
    repeat (2) @(posedge clk);
    #2 chk_h("reset_state", 8, 0, 0, 0, 0);
    expect_now("reset_state_direct", {5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0});
    rst = 1'b0;
    bus.code = 4'hA; bus.enter = 1'b1;
    step(1); chk("closed_code_ignored_a", 0, 0, 0, 0); bus.enter = 1'b0;
    step(2); chk("closed_code_ignored_b", 0, 0, 0, 0);
    step(4); chk_h("hour10_open", 10, 0, 0, 0, 0); bus.enter = 1'b1;
    step(5); bus.enter = 1'b0;
    for (int c = 5; c <= 12; c++) begin
      step(c);
      chk($sformatf("unlock_window_c%0d", c), 1, 0, 0, 0);
    end
    step(13); chk("unlock_window_end", 0, 0, 0, 0);
    expect_now("unlock_expired", {5'd14, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0});
    step(20); bus.door_open = 1'b1;
    step(21); chk("alarm_set", 0, 0, 1, 0); bus.mgr_key = 1'b1;
    step(22); chk("alarm_set_wins", 0, 0, 1, 0); bus.mgr_key = 1'b0; bus.door_open = 1'b0;
    step(23); chk("alarm_sticky", 0, 0, 1, 0); bus.mgr_key = 1'b1;
    step(24); chk("alarm_cleared", 0, 0, 0, 0); bus.mgr_key = 1'b0;
    step(31); chk_h("hour23", 23, 0, 0, 0, 0);
    step(32); chk_h("hour_wrap0", 0, 0, 0, 0, 0);
    step(33); chk_h("hour0_hold", 0, 0, 0, 0, 0);
    step(34); chk_h("hour1", 1, 0, 0, 0, 0);
    step(52); bus.code = 4'h3; bus.enter = 1'b1;
    step(53); chk("wrong1", 0, 0, 0, LE ? 1 : 0); bus.enter = 1'b0;
    step(54); bus.enter = 1'b1;
    step(55); chk("wrong2", 0, 0, 0, LE ? 2 : 0); bus.enter = 1'b0;
    step(56); bus.enter = 1'b1;
    step(57); chk("wrong3_lockout", 0, LE, 0, LE ? 3 : 0); bus.enter = 1'b0;
    step(58); bus.code = 4'hA;
`ifdef COFRE_LOCKOUT_EN
    bus.enter = 1'b1;
`endif
    step(59); chk("lockout_ignores_code", 0, LE, 0, LE ? 3 : 0); bus.enter = 1'b0; bus.mgr_key = 1'b1;
    step(60); chk("mgr_clears_lockout", 0, 0, 0, 0); bus.mgr_key = 1'b0;
    step(61); bus.code = 4'h3; bus.enter = 1'b1; bus.mgr_key = 1'b1;
    step(62); chk("simult_enter_mgr", 0, 0, 0, 0); bus.enter = 1'b0; bus.mgr_key = 1'b0; bus.code = 4'hA;
    step(63); bus.enter = 1'b1;
    step(64); chk_h("unlock_at_close", 16, 1, 0, 0, 0); bus.enter = 1'b0; bus.door_open = 1'b1;
    step(65); chk("unlock_drops_after_close", 0, 0, 0, 0);
    step(66); chk("alarm_after_close", 0, 0, 1, 0); bus.door_open = 1'b0;
    step(67); bus.mgr_key = 1'b1;
    step(68); chk("alarm_cleared_2", 0, 0, 0, 0); bus.mgr_key = 1'b0;
    step(100); bus.code = 4'hA; bus.enter = 1'b1;
    step(101); chk("unlock_day3", 1, 0, 0, 0); bus.enter = 1'b0;
    step(103); chk("unlock_day3_mid", 1, 0, 0, 0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 chk_h("reset_mid_unlock", 8, 0, 0, 0, 0);
    -> sample_now;
    expect_now("reset_mid_unlock_direct", {5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0});
    @(posedge clk);
    #2 rst = 1'b0;
    step(1); chk("after_reset", 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cofre_timelock.md
# cofre_timelock

Vault time-lock and access controller for the bank-branch lab board. It generates the signals that the vault alarm logic consumes: a business-hours flag from an internal hour clock, a timed door-unlock window after a correct code entry, a wrong-code lockout, and a sticky alarm. It sits between the switches (code, enter, door sensor, manager key) and the LED/alarm outputs, all clocked by `clk_2`.

## Interface
- `TICKS_PER_HOUR`, default 30: `clk_2` cycles per simulated hour (≥1).
- `RESET_HOUR`, default 8: hour value loaded at reset (0–23).
- `OPEN_HOUR`, default 10: first business hour, inclusive.
- `CLOSE_HOUR`, default 16: end of business hours, exclusive. OPEN_HOUR < CLOSE_HOUR.
- `CODE`, default 4'hA: access code.
- `MAX_TRIES`, default 3: consecutive wrong codes that trigger lockout (1–7).
- `UNLOCK_CYCLES`, default 8: unlock window length in cycles (≥1).

Ports:
- `clk_2`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `code`  in  4  code switches.
- `enter`  in  1  enter switch, level; its rising edge submits `code`.
- `door_open`  in  1  door sensor, 1 = open.
- `mgr_key`  in  1  manager key, level; its rising edge clears the alarm and the lockout.
- `hour`  out  5  current hour, 0–23.
- `expediente`  out  1  business hours: OPEN_HOUR ≤ hour < CLOSE_HOUR.
- `unlock`  out  1  door unlocked.
- `lockout`  out  1  lockout active.
- `alarm`  out  1  sticky alarm.
- `tries`  out  3  current wrong-code count.

## Operation
- All inputs are already synchronous to `clk_2`. Edge detectors register `enter` and `mgr_key`. An edge is `x & ~x_q`.
- Hour clock: the prescaler counts 0..TICKS_PER_HOUR-1. At terminal count, the prescaler returns to 0 and `hour` increments, wrapping from 23 to 0. It runs in every state.
- FSM states: LOCKED, UNLOCKED, LOCKOUT.
- LOCKED:
  - An `enter` edge while `expediente`=0 is ignored, and `tries` is unchanged.
  - An `enter` edge while `expediente`=1 with `code`==CODE goes to UNLOCKED, clears `tries`, and loads the window counter with UNLOCK_CYCLES.
  - An `enter` edge while `expediente`=1 with a wrong code increments `tries`. If the new value equals MAX_TRIES, the FSM goes to LOCKOUT.
- UNLOCKED:
  - The window counter decrements each cycle. The FSM returns to LOCKED on the cycle after the counter reaches 1.
  - If `expediente` falls, the FSM returns to LOCKED immediately, on the next edge.
  - `enter` edges are ignored.
- LOCKOUT: `enter` edges are ignored. An `mgr_key` edge goes to LOCKED and clears `tries`.
- Alarm: set when `door_open`=1 and `unlock`=0. It stays set until an `mgr_key` edge in a cycle where the set condition is false. The set condition wins over the clear.
- Simultaneous `enter` edge and `mgr_key` edge: `mgr_key` is processed, and that `enter` edge is discarded.
- `unlock` = state is UNLOCKED. `lockout` = state is LOCKOUT.

## Timing
- Reset (async, immediate):
  - state = LOCKED; `hour` = RESET_HOUR; prescaler = 0.
  - `tries` = 0, `unlock` = 0, `lockout` = 0, `alarm` = 0.
  - Edge registers = 0, so a switch held high during reset does not produce an edge after release.
  - `expediente` follows from `hour`.
- Reset mid-unlock or mid-lockout aborts to LOCKED in the same instant.
- All outputs are registered except `expediente`, which is combinational from the `hour` register.
- `enter` rises in cycle N, where the edge is seen. `unlock`/`tries`/`lockout` update at the N+1 edge.
- `unlock` is high for exactly UNLOCK_CYCLES cycles unless cut short by `expediente` falling.
- `alarm` rises one cycle after the first cycle with `door_open & ~unlock`.
- `hour` changes one cycle after prescaler terminal count. The hour period is exactly TICKS_PER_HOUR cycles.

## Configuration
- `COFRE_LOCKOUT_EN` defined: the `tries` counter, the LOCKOUT state, and lockout-by-manager-key behave as above.
- `COFRE_LOCKOUT_EN` undefined:
  - Wrong codes leave the FSM in LOCKED with no effect.
  - `tries` and `lockout` are tied to 0, and the LOCKOUT state is not built.
  - `mgr_key` only clears the alarm.

## Test plan
- Reset with defaults, TICKS_PER_HOUR=2 -> `hour`=8, `expediente`=0. After 4 cycles `hour`=10 and `expediente`=1. `hour` wraps 23→0 with correct period.
- At hour 10, code=4'hA, `enter` pulse -> `unlock`=1 for exactly 8 cycles, `tries`=0. The same entry at hour 8 -> no change.
- Three wrong entries (4'h3) during business hours -> `tries` 1, 2, then `lockout`=1 with `tries`=3. A correct code is then ignored. An `mgr_key` edge -> LOCKED, `tries`=0. Repeat with `COFRE_LOCKOUT_EN` undefined -> `lockout` stays 0.
- `door_open`=1 while LOCKED -> `alarm`=1 next cycle. `mgr_key` edge with door still open -> `alarm` stays 1. Close the door, then `mgr_key` edge -> `alarm`=0.
- Unlock granted at hour 15, window crosses into hour 16 -> `unlock` drops the cycle after `expediente` falls. Door open at that point -> `alarm`=1.
- `enter` and `mgr_key` rise in the same cycle while LOCKED with a wrong code -> `tries` unchanged. Assert `reset` mid-UNLOCKED -> `unlock`=0 and `hour`=8 immediately.
